fifo_wr_arbiter: RTL and testbench

//  - Shares the single write port of fifo_buffer between NUM_REQ sensor/event requesters.
//  - Requesters are temperature, door, compressor and alarm logging sources.
//  - Arbitration is round-robin. Writes are paced so fifo_buffer's registered full/almost_full flags are settled before each decision.
//  - Sits between the sensor front-ends and fifo_buffer, in the clk_1MHz domain.

---
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing fifo_buffer's single write port, with a 3-cycle write cadence.
// Optional `ARB_PRIO0_EN: requester 0 (alarm) gets fixed priority and may use the last FIFO slot.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk_1MHz,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          stall,
  output logic [1:0]                    fsm_state
);

  // Handshake: req[i] is valid, ack[i] is the one-cycle ready/taken pulse; the requester
  // holds req[i] and its word stable until it samples ack[i]=1, then may drop or reload.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    COOL1 = 2'd2,
    COOL2 = 2'd3
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] last;

  logic [ID_WIDTH-1:0] rr_win;
  logic                rr_found;
  int                  idx;

  // Rotating search starting just after the previous round-robin winner.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!rr_found && req[idx[ID_WIDTH-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = idx[ID_WIDTH-1:0];
      end
    end
  end

  logic                  grant_ok;
  logic                  grant_upd_last;
  logic [ID_WIDTH-1:0]   grant_win;
  logic [NUM_REQ-1:0]    win_onehot;
  logic [DATA_WIDTH-1:0] win_word;

  always_comb begin
    grant_ok       = 1'b0;
    grant_upd_last = 1'b0;
    grant_win      = '0;
`ifdef ARB_PRIO0_EN
    // Alarm word bypasses the rotation and may take the final slot; pointer stays put.
    if (req[0] && !fifo_full) begin
      grant_ok = 1'b1;
      grant_win = '0;
    end else if (rr_found && !fifo_full && !fifo_almost_full) begin
      grant_ok       = 1'b1;
      grant_upd_last = 1'b1;
      grant_win      = rr_win;
    end
`else
    if (rr_found && !fifo_full && !fifo_almost_full) begin
      grant_ok       = 1'b1;
      grant_upd_last = 1'b1;
      grant_win      = rr_win;
    end
`endif
  end

  always_comb begin
    win_onehot            = '0;
    win_onehot[grant_win] = 1'b1;
    win_word              = req_data[int'(grant_win)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      ack          <= '0;
      stall        <= 1'b0;
      grant_id     <= '0;
      last         <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      stall      <= (|req) && (fifo_full || fifo_almost_full);
      fifo_wr_en <= 1'b0;
      ack        <= '0;
      case (state)
        IDLE, COOL2: begin
          if (grant_ok) begin
            fifo_wr_en   <= 1'b1;
            fifo_data_in <= win_word;
            ack          <= win_onehot;
            grant_id     <= grant_win;
            if (grant_upd_last) last <= grant_win;
            state        <= WRITE;
          end else begin
            state <= IDLE;
          end
        end
        // Two cool-down cycles let fifo_buffer's registered flags reflect the last write.
        WRITE:   state <= COOL1;
        COOL1:   state <= COOL2;
        default: state <= IDLE;
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, corner-case sequences, randomized run vs reference model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

`ifdef ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk_1MHz = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        fifo_full;
  logic        fifo_almost_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_in;
  logic [1:0]  grant_id;
  logic        stall;
  logic [1:0]  fsm_state;

  logic drv_full, drv_af, use_fm, fm_rd, fm_clear;
  int   fm_count;
  logic fm_full, fm_af;

  int n_pass, n_total;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk_1MHz(clk_1MHz), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id), .stall(stall), .fsm_state(fsm_state)
  );

  // Clock / reset block
  always #500 clk_1MHz = ~clk_1MHz;

  // Depth-4 FIFO occupancy model with registered flags lagging the count.
  always @(posedge clk_1MHz) begin
    if (fm_clear) begin
      fm_count <= 0;
      fm_full  <= 1'b0;
      fm_af    <= 1'b0;
    end else begin
      fm_count <= fm_count + ((fifo_wr_en && fm_count < 4) ? 1 : 0) - ((fm_rd && fm_count > 0) ? 1 : 0);
      fm_full  <= (fm_count == 4);
      fm_af    <= (fm_count >= 3);
    end
  end

  assign fifo_full        = use_fm ? fm_full : drv_full;
  assign fifo_almost_full = use_fm ? fm_af   : drv_af;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk_1MHz);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; drv_full = 1'b0; drv_af = 1'b0;
    use_fm = 1'b0; fm_rd = 1'b0; fm_clear = 1'b1;
    tick(); tick();
    rst_n = 1'b1; fm_clear = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic       af;
    logic       wr;
    logic [3:0] ack;
    logic [1:0] gid;
    logic       stall;
  } vec_t;

  vec_t tbl[19];
  localparam logic [31:0] TBL_DATA = 32'h4433_22A5;

  // Reference-model state for the randomized run
  int          m_last, m_wait;
  logic [1:0]  m_gid;
  logic [3:0]  s_req;
  logic [31:0] s_data;
  logic        s_full, s_af;
  logic        e_wr, e_stall;
  logic [3:0]  e_ack;
  logic [7:0]  e_data;
  logic [31:0] tdata;
  logic [31:0] exp_q[$];

  initial begin
    int ng, last_c, nw, win;
    int seq5[5];
    n_pass = 0; n_total = 0;

    // Reset state: async reset dominates busy inputs
    rst_n = 1'b0; req = 4'b1111; req_data = 32'h1122_3344; drv_full = 1'b0; drv_af = 1'b1;
    use_fm = 1'b0; fm_rd = 1'b0; fm_clear = 1'b1;
    tick(); tick();
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_data", 32'(fifo_data_in), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    // Table-driven single-cycle vectors from reset
    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[2]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[3]  = '{4'b0110, 1'b0, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0};
    tbl[4]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0};
    tbl[5]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1};
    tbl[6]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1};
    tbl[7]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b0};
    tbl[8]  = '{4'b1010, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0};
    tbl[9]  = '{4'b1010, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0};
    tbl[10] = '{4'b1010, 1'b0, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b0};
    tbl[11] = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0};
    tbl[12] = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0};
    tbl[13] = '{4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b0};
    tbl[14] = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1};
    tbl[15] = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1};
    tbl[16] = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1};
    tbl[17] = '{4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0};
    tbl[18] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
    do_reset();
    req_data = TBL_DATA;
    tdata = TBL_DATA;
    for (int i = 0; i < 19; i++) begin
      req = tbl[i].req; drv_full = tbl[i].full; drv_af = tbl[i].af;
      tick();
      check($sformatf("tbl%0d_wr", i), 32'(fifo_wr_en), 32'(tbl[i].wr));
      check($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
      check($sformatf("tbl%0d_gid", i), 32'(grant_id), 32'(tbl[i].gid));
      check($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].stall));
      if (tbl[i].wr)
        check($sformatf("tbl%0d_data", i), 32'(fifo_data_in), 32'(tdata[int'(tbl[i].gid)*8 +: 8]));
    end

    // All requesters held: rotation order and 3-cycle cadence
    do_reset();
    req_data = 32'hD4C3_B2A1; req = 4'b1111;
    ng = 0; last_c = -1;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      tick();
      if (fifo_wr_en) begin
        win = PRIO ? 0 : ng % 4;
        check("t2_order", 32'(grant_id), 32'(win));
        check("t2_ack", 32'(ack), 32'(4'b0001 << win));
        if (ng > 0) check("t2_spacing", 32'(c - last_c), 32'd3);
        last_c = c; ng++;
      end
    end
    check("t2_count", 32'(ng), 32'd6);

    // Depth-4 FIFO, no reads: capacity limit, then one read frees one write
    do_reset();
    use_fm = 1'b1; req = 4'b1111;
    nw = 0; ng = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (fifo_wr_en) nw++;
      if (fifo_wr_en && fm_full) ng++;
    end
    check("t3_writes", 32'(nw), PRIO ? 32'd4 : 32'd3);
    check("t3_stall", 32'(stall), 32'd1);
    fm_rd = 1'b1; tick(); fm_rd = 1'b0;
    nw = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (fifo_wr_en) nw++;
      if (fifo_wr_en && fm_full) ng++;
    end
    check("t3_after_read", 32'(nw), 32'd1);
    check("t3_no_wr_when_full", 32'(ng), 32'd0);
    use_fm = 1'b0;

    // Reset asserted during WRITE: outputs drop at once, write abandoned
    do_reset();
    req_data = 32'h4433_2211; req = 4'b0010;
    tick();
    check("t4_pre_wr", 32'(fifo_wr_en), 32'd1);
    #100 rst_n = 1'b0;
    #1;
    check("t4_async_wr", 32'(fifo_wr_en), 32'd0);
    check("t4_async_ack", 32'(ack), 32'd0);
    req = 4'b0100;
    tick();
    rst_n = 1'b1;
    tick();
    check("t4_wr", 32'(fifo_wr_en), 32'd1);
    check("t4_gid", 32'(grant_id), 32'd2);
    check("t4_ack", 32'(ack), 32'b0100);
    check("t4_data", 32'(fifo_data_in), 32'h33);

`ifdef ARB_PRIO0_EN
    // Alarm raised mid-stream wins next, rotation resumes after previous winner
    do_reset();
    req_data = 32'h4433_2211; req = 4'b1110;
    seq5 = '{1, 2, 0, 3, 1};
    ng = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      tick();
      if (fifo_wr_en) begin
        check("t5_order", 32'(grant_id), 32'(seq5[ng]));
        if (seq5[ng] == 0) req[0] = 1'b0;
        ng++;
        if (ng == 2) req[0] = 1'b1;
      end
    end
    check("t5_count", 32'(ng), 32'd5);
`endif

    // almost_full with only requester 0 pending
    do_reset();
    req_data = 32'h0000_005A; drv_af = 1'b1; req = 4'b0001;
    nw = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (fifo_wr_en) begin
        nw++;
        req[0] = 1'b0;
      end
    end
    check("t6_writes", 32'(nw), PRIO ? 32'd1 : 32'd0);
    check("t6_stall", 32'(stall), PRIO ? 32'd0 : 32'd1);

    // Randomized traffic against the reference model
    do_reset();
    m_last = 3; m_wait = 0; m_gid = 2'd0;
    req_data = $urandom;
    req = 4'($urandom_range(0, 15));
    for (int c = 0; c < 1500; c++) begin
      drv_af   = ($urandom_range(0, 5) == 0);
      drv_full = drv_af && ($urandom_range(0, 1) == 1);
      s_req = req; s_data = req_data; s_full = drv_full; s_af = drv_af;
      tick();
      e_stall = (s_req != 4'b0) && (s_full || s_af);
      e_wr = 1'b0; e_ack = 4'b0; e_data = 8'h0;
      if (m_wait > 0) begin
        m_wait--;
      end else begin
        win = -1;
        if (PRIO && s_req[0] && !s_full) begin
          win = 0;
        end else if (s_req != 4'b0 && !s_full && !s_af) begin
          for (int k = 1; k <= 4 && win < 0; k++)
            if (s_req[(m_last + k) % 4]) win = (m_last + k) % 4;
          m_last = win;
        end
        if (win >= 0) begin
          e_wr = 1'b1; e_ack = 4'b0001 << win; e_data = s_data[win*8 +: 8];
          m_gid = 2'(win); m_wait = 2;
        end
      end
      if (e_wr) exp_q.push_back({24'b0, e_data});
      check("rnd_wr", 32'(fifo_wr_en), 32'(e_wr));
      check("rnd_ack", 32'(ack), 32'(e_ack));
      check("rnd_gid", 32'(grant_id), 32'(m_gid));
      check("rnd_stall", 32'(stall), 32'(e_stall));
      if (e_wr) check("rnd_data", 32'(fifo_data_in), exp_q.pop_front());
      for (int i = 0; i < 4; i++) begin
        if (e_ack[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else req_data[i*8 +: 8] = 8'($urandom_range(0, 255));
        end else if (!req[i] && $urandom_range(0, 4) == 0) begin
          req[i] = 1'b1;
          req_data[i*8 +: 8] = 8'($urandom_range(0, 255));
        end
      end
    end

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
